// File: rtl/qracc_pkg.sv
// qracc_pkg: shared types for the QR-accelerator SRAM request interface.
//   sram_rsp_state_t : sequencing states of sram_rq_responder
//   SRAM_RSP_CNT_W   : width of the responder's phase down-counter
//   to_sram_t / from_sram_t : request/response bundles (default 128x32 macro)
//   cnt_load()       : counter preload for a phase lasting n cycles
package qracc_pkg;

    localparam int unsigned SRAM_RSP_CNT_W = 8;
    localparam int unsigned QRACC_ROWS     = 128;
    localparam int unsigned QRACC_COLS     = 32;

    typedef enum logic [2:0] {
        StIdle,
        StPch,
        StWlon,
        StSense,
        StDone,
        StRec
    } sram_rsp_state_t;

    typedef struct packed {
        logic                          rq_valid_i;
        logic                          rq_wr_i;
        logic [$clog2(QRACC_ROWS)-1:0] addr_i;
        logic [QRACC_COLS-1:0]         wr_data_i;
    } to_sram_t;

    typedef struct packed {
        logic                  rq_ready_o;
        logic                  rd_valid_o;
        logic [QRACC_COLS-1:0] rd_data_o;
    } from_sram_t;

    // A phase of n cycles counts n-1 down to 0.
    function automatic logic [SRAM_RSP_CNT_W-1:0] cnt_load(input int unsigned n);
        return SRAM_RSP_CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/sram_wl_decoder.sv
// sram_wl_decoder: row address + enable -> one-hot wordline vector.
//   i_addr     row address
//   i_en       drive a wordline
//   o_wl       one-hot wordline, all-zero when disabled or out of range
//   o_in_range i_addr < NumRows
module sram_wl_decoder #(
    parameter int unsigned NumRows = 128,
    parameter int unsigned AddrW   = $clog2(NumRows)
) (
    input  logic [AddrW-1:0]   i_addr,
    input  logic               i_en,
    output logic [NumRows-1:0] o_wl,
    output logic               o_in_range
);

    always_comb begin
        o_wl       = '0;
        o_in_range = (32'(i_addr) < NumRows);
        if (i_en && o_in_range) begin
            o_wl[i_addr] = 1'b1;
        end
    end

endmodule

// File: rtl/sram_rq_responder.sv
// sram_rq_responder: responder for single-word SRAM read/write requests.
// Sequences precharge, wordline, write driver and sense amp of the macro and
// returns captured SA_OUT data. All outputs are registered.
//   clk, rst                       clock, async active-high reset
//   rq_valid_i/rq_wr_i/addr_i/wr_data_i  request, accepted with rq_ready_o
//   mac_en_i                       MAC mode, blocks new accepts
//   rq_ready_o, rd_valid_o, rd_data_o   handshake and read response
//   SA_OUT                         sense-amp outputs from the macro
//   WL, PCH, WRITE, WR_DATA, CSEL, SAEN  macro controls
//   wr_err_o                       (SRAM_WR_VERIFY_EN only) write-verify mismatch pulse
// Optional feature macro: SRAM_WR_VERIFY_EN adds a read-back after every write.
module sram_rq_responder
    import qracc_pkg::*;
#(
    parameter int unsigned numRows   = 128,
    parameter int unsigned numCols   = 32,
    parameter int unsigned pchCycles = 1,
    parameter int unsigned wlCycles  = 2,
    parameter int unsigned saCycles  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rq_valid_i,
    input  logic                       rq_wr_i,
    input  logic [$clog2(numRows)-1:0] addr_i,
    input  logic [numCols-1:0]         wr_data_i,
    input  logic                       mac_en_i,
    output logic                       rq_ready_o,
    output logic                       rd_valid_o,
    output logic [numCols-1:0]         rd_data_o,
    input  logic [numCols-1:0]         SA_OUT,
    output logic [numRows-1:0]         WL,
    output logic                       PCH,
    output logic                       WRITE,
    output logic [numCols-1:0]         WR_DATA,
    output logic [numCols-1:0]         CSEL,
`ifdef SRAM_WR_VERIFY_EN
    output logic                       wr_err_o,
`endif
    output logic                       SAEN
);

    localparam int unsigned AddrW = $clog2(numRows);

    sram_rsp_state_t            r_state, w_state_d;
    logic [SRAM_RSP_CNT_W-1:0]  r_cnt, w_cnt_d;
    logic                       r_wr;
    logic [AddrW-1:0]           r_addr;
    logic [numCols-1:0]         r_wdata;
    logic                       r_verify, w_verify_d;   // read-back pass of a write
    logic                       w_accept;
    logic                       w_capture;
    logic                       w_wl_en;
    logic                       w_write_d;
    logic [numRows-1:0]         w_wl;
    logic                       w_in_range;

    assign w_accept = rq_valid_i && rq_ready_o;

    always_comb begin
        w_state_d  = r_state;
        w_cnt_d    = r_cnt;
        w_verify_d = r_verify;
        w_capture  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_d  = StPch;
                    w_cnt_d    = cnt_load(pchCycles);
                    w_verify_d = 1'b0;
                end
            end
            StPch: begin
                if (r_cnt == '0) begin
                    w_state_d = StWlon;
                    w_cnt_d   = cnt_load(wlCycles);
                end else begin
                    w_cnt_d = r_cnt - 1'b1;
                end
            end
            StWlon: begin
                if (r_cnt != '0) begin
                    w_cnt_d = r_cnt - 1'b1;
                end else if (r_wr && !r_verify) begin
`ifdef SRAM_WR_VERIFY_EN
                    w_state_d  = StPch;
                    w_cnt_d    = cnt_load(pchCycles);
                    w_verify_d = 1'b1;
`else
                    w_state_d = StRec;
`endif
                end else begin
                    w_state_d = StSense;
                    w_cnt_d   = cnt_load(saCycles);
                end
            end
            StSense: begin
                if (r_cnt == '0) begin
                    w_state_d = StDone;
                    w_capture = 1'b1;
                end else begin
                    w_cnt_d = r_cnt - 1'b1;
                end
            end
            // A verify pass still owes the write recovery cycle.
            StDone:  w_state_d = r_verify ? StRec : StIdle;
            StRec:   w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    assign w_wl_en   = (w_state_d == StWlon) || (w_state_d == StSense);
    assign w_write_d = (w_state_d == StWlon) && r_wr && !w_verify_d;

    sram_wl_decoder #(
        .NumRows (numRows),
        .AddrW   (AddrW)
    ) u_wl_decoder (
        .i_addr     (r_addr),
        .i_en       (w_wl_en),
        .o_wl       (w_wl),
        .o_in_range (w_in_range)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_wr       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_verify   <= 1'b0;
            rq_ready_o <= 1'b0;
            rd_valid_o <= 1'b0;
            rd_data_o  <= '0;
            WL         <= '0;
            PCH        <= 1'b0;
            WRITE      <= 1'b0;
            WR_DATA    <= '0;
            CSEL       <= '0;
            SAEN       <= 1'b0;
`ifdef SRAM_WR_VERIFY_EN
            wr_err_o   <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_d;
            r_cnt      <= w_cnt_d;
            r_verify   <= w_verify_d;
            if (w_accept) begin
                r_wr    <= rq_wr_i;
                r_addr  <= addr_i;
                r_wdata <= wr_data_i;
            end
            rq_ready_o <= (w_state_d == StIdle) && !mac_en_i;
            rd_valid_o <= (w_state_d == StDone) && !w_verify_d;
            if (w_capture && !r_verify) begin
                rd_data_o <= w_in_range ? SA_OUT : '0;
            end
            WL         <= w_wl;
            PCH        <= (w_state_d == StPch);
            WRITE      <= w_write_d;
            WR_DATA    <= w_write_d ? r_wdata : '0;
            CSEL       <= (w_state_d == StWlon) ? '1 : '0;
            SAEN       <= (w_state_d == StSense);
`ifdef SRAM_WR_VERIFY_EN
            wr_err_o   <= w_capture && r_verify && (SA_OUT != r_wdata);
`endif
        end
    end

endmodule
